// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared types and constants for the multiply/divide scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int MULDIV_STEPS = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } muldiv_state_t;

  typedef struct packed {
    logic                    valid;
    muldiv_op_t              op;
    logic [MULDIV_STEPS-1:0] a;
    logic [MULDIV_STEPS-1:0] b;
  } muldiv_req_t;

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_if
// Brief    : Lane request / result bus between the execute lanes and the
//            shared multiply/divide scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
  parameter int XLEN   = 32,
  parameter int LANES  = 2,
  parameter int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
);
  logic [LANES-1:0]           req_valid;
  logic [LANES-1:0][1:0]      req_op;
  logic [LANES-1:0][XLEN-1:0] req_a;
  logic [LANES-1:0][XLEN-1:0] req_b;
  logic [LANES-1:0]           req_ready;
  logic                       flush;
  logic                       busy;
  logic                       resp_valid;
  logic [LANE_W-1:0]          resp_lane;
  logic [XLEN-1:0]            resp_hi;
  logic [XLEN-1:0]            resp_lo;
  logic                       resp_ready;

  // Pipeline side: issues requests, consumes results
  modport master (
    output req_valid, req_op, req_a, req_b, flush, resp_ready,
    input  req_ready, busy, resp_valid, resp_lane, resp_hi, resp_lo
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_op, req_a, req_b, flush, resp_ready,
    output req_ready, busy, resp_valid, resp_lane, resp_hi, resp_lo
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_engine.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_engine
// Brief    : Iterative unsigned shift-add multiplier / restoring divider.
//            One step per cycle while step is high; no sequencing of its own.
//            acc shows the post-step value during a step, else the held value,
//            so the owner can capture the final step without an extra cycle.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_engine #(
  parameter int XLEN = 32
) (
  input  wire logic              clk,
  input  wire logic              resetn,
  input  wire logic              start,
  input  wire logic              step,
  input  wire logic              op_is_div,
  input  wire logic [XLEN-1:0]   a,
  input  wire logic [XLEN-1:0]   b,
  output logic      [2*XLEN-1:0] acc
);

  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN-1:0]   m_q;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_trial;
  logic [XLEN-1:0]   div_diff;
  logic              div_fits;

  // Next accumulator value for one multiply or divide step
  always_comb begin
    // Multiply: low half holds the multiplier, shifted out LSB-first
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});
    // Divide: partial remainder shifted left by one can reach XLEN+1 bits
    rem_trial = acc_q[2*XLEN-1:XLEN-1];
    div_fits  = (rem_trial >= {1'b0, m_q});
    div_diff  = rem_trial[XLEN-1:0] - m_q;
    if (op_is_div) begin
      if (div_fits) begin
        acc_step = {div_diff, acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_step = {acc_q[2*XLEN-2:0], 1'b0};
      end
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  assign acc = step ? acc_step : acc_q;

  // Operand load on start, accumulator advance on step
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q <= '0;
      m_q   <= '0;
    end else if (start) begin
      acc_q <= {{XLEN{1'b0}}, a};
      m_q   <= b;
    end else if (step) begin
      acc_q <= acc_step;
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_scheduler
// Brief    : Arbitrates the execute lanes onto one iterative mul/div engine,
//            converts signed operands to magnitudes, restores the result sign
//            and holds {hi, lo} until the owning lane consumes it.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_scheduler
  import muldiv_pkg::*;
#(
  parameter int XLEN  = MULDIV_STEPS,
  parameter int LANES = 2
) (
  input  wire logic clk,
  input  wire logic resetn,
  muldiv_if.slave   bus
);

  localparam int CNT_W  = $clog2(XLEN);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  muldiv_state_t     state, state_nxt;
  logic [CNT_W-1:0]  counter;
  muldiv_op_t        op_q;
  logic [LANE_W-1:0] lane_q;
  logic              sign_a_q, sign_b_q, b_zero_q;
  logic [XLEN-1:0]   hi_q, lo_q;

  logic              any_valid;
  logic [LANE_W-1:0] sel_lane;
  muldiv_op_t        sel_op;
  logic [XLEN-1:0]   sel_a, sel_b, mag_a, mag_b;
  logic              sel_sign_a, sel_sign_b;
  logic              grant, step_en, last_step, engine_div;
  logic [LANES-1:0]  ready_vec;
  logic [2*XLEN-1:0] acc, prod;
  logic [XLEN-1:0]   quo, rem, fix_hi, fix_lo;

  // Fixed priority: the lowest-numbered (oldest) requesting lane wins
  always_comb begin
    any_valid = |bus.req_valid;
    sel_lane  = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) sel_lane = LANE_W'(i);
    end
  end

  // Operand conditioning for the winning lane; the most negative value maps
  // onto its own bit pattern, which is the correct unsigned magnitude
  always_comb begin
    sel_op     = muldiv_op_t'(bus.req_op[sel_lane]);
    sel_a      = bus.req_a[sel_lane];
    sel_b      = bus.req_b[sel_lane];
    sel_sign_a = op_is_signed(sel_op) & sel_a[XLEN-1];
    sel_sign_b = op_is_signed(sel_op) & sel_b[XLEN-1];
    mag_a      = sel_sign_a ? -sel_a : sel_a;
    mag_b      = sel_sign_b ? -sel_b : sel_b;
  end

  assign last_step  = (counter == CNT_W'(XLEN - 1));
  assign step_en    = (state == S_BUSY) && !bus.flush;
  assign engine_div = op_is_div(op_q);

  muldiv_engine #(
    .XLEN (XLEN)
  ) u_engine (
    .clk       (clk),
    .resetn    (resetn),
    .start     (grant),
    .step      (step_en),
    .op_is_div (engine_div),
    .a         (mag_a),
    .b         (mag_b),
    .acc       (acc)
  );

  // Sign restoration of the raw unsigned engine result
  always_comb begin
    prod = (sign_a_q ^ sign_b_q) ? -acc : acc;
    quo  = acc[XLEN-1:0];
    rem  = acc[2*XLEN-1:XLEN];
    if (engine_div) begin
      // Divide by zero: remainder magnitude is |a|, so sign restore yields raw a
      fix_lo = b_zero_q ? {XLEN{1'b1}} : ((sign_a_q ^ sign_b_q) ? -quo : quo);
      fix_hi = sign_a_q ? -rem : rem;
    end else begin
      fix_hi = prod[2*XLEN-1:XLEN];
      fix_lo = prod[XLEN-1:0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state and grant decode; reset also suppresses the combinational grant
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    ready_vec = '0;
    unique case (state)
      S_IDLE: begin
        if (resetn && !bus.flush && any_valid) begin
          grant     = 1'b1;
          ready_vec = LANES'(1) << sel_lane;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.flush)     state_nxt = S_IDLE;
        else if (last_step) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.flush || bus.resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request capture, step counting and result hold
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      counter  <= '0;
      op_q     <= MD_MULT;
      lane_q   <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (grant) begin
      counter  <= '0;
      op_q     <= sel_op;
      lane_q   <= sel_lane;
      sign_a_q <= sel_sign_a;
      sign_b_q <= sel_sign_b;
      b_zero_q <= (sel_b == '0);
    end else if (step_en) begin
      counter <= counter + 1'b1;
      if (last_step) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end
    end
  end

  assign bus.req_ready  = ready_vec;
  assign bus.busy       = (state != S_IDLE);
  assign bus.resp_valid = (state == S_DONE);
  assign bus.resp_lane  = lane_q;
  assign bus.resp_hi    = hi_q;
  assign bus.resp_lo    = lo_q;

endmodule
`default_nettype wire
